// File: rtl/tuner_search_host.sv
// Host side of the tuner search: one lock command triggers sweeps, the host selects a peak and returns a lock result.
// Latency: command to trigger 1 cycle, peaks handshake to lock valid 2 cycles. Failed sweeps retry up to MAX_RETRY times.
// Backpressure: the trigger is held until accepted and the lock result is held stable until i_lock_rdy. Optional macro: TUNER_SEARCH_HOST_MAXPWR_EN.
module tuner_search_host #(
    parameter int DAC_WIDTH      = 8,
    parameter int ADC_WIDTH      = 8,
    parameter int NUM_TARGET     = 4,
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_cmd_val,
    output logic                                  o_cmd_rdy,
    input  logic [$clog2(NUM_TARGET)-1:0]         i_cmd_target_idx,
    output logic                                  o_search_trig_val,
    input  logic                                  i_search_trig_rdy,
    input  logic                                  i_search_peaks_val,
    output logic                                  o_search_peaks_rdy,
    input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]  i_search_ring_tune_peaks,
    input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]  i_search_pwr_peaks,
    input  logic [$clog2(NUM_TARGET)-1:0]         i_search_peaks_cnt,
    output logic                                  o_lock_val,
    input  logic                                  i_lock_rdy,
    output logic [DAC_WIDTH-1:0]                  o_lock_ring_tune,
    output logic [ADC_WIDTH-1:0]                  o_lock_pwr,
    output logic                                  o_lock_err,
    output logic [$clog2(MAX_RETRY+1)-1:0]        o_mon_retry_cnt
);

    localparam int IW = $clog2(NUM_TARGET);
    localparam int RW = $clog2(MAX_RETRY+1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES-1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT, SELECT, LOCK} state_t;

    state_t                                 state, state_nxt;
    logic [IW-1:0]                          tgt_idx;
    logic [RW-1:0]                          retry_cnt;
    logic [TW-1:0]                          tmo_cnt;
    logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]   tbl_tune;
    logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]   tbl_pwr;
    logic [IW-1:0]                          tbl_cnt;
    logic [DAC_WIDTH-1:0]                   lock_tune;
    logic [ADC_WIDTH-1:0]                   lock_pwr;
    logic                                   lock_err;

    logic                                   sel_ok;
    logic [DAC_WIDTH-1:0]                   sel_tune;
    logic [ADC_WIDTH-1:0]                   sel_pwr;
    logic                                   sweep_fail;
    logic                                   retry_ok;

    // Peak selection works on the registered table only, so SELECT stays a single cycle.
    always_comb begin
        sel_ok   = tbl_cnt > tgt_idx;
        sel_tune = tbl_tune[tgt_idx];
        sel_pwr  = tbl_pwr[tgt_idx];
`ifdef TUNER_SEARCH_HOST_MAXPWR_EN
        begin
            logic [IW-1:0]        best_idx;
            logic [ADC_WIDTH-1:0] best_pwr;
            best_idx = '0;
            best_pwr = '0;
            // Strict compare keeps the lowest index on ties.
            for (int i = 0; i < NUM_TARGET; i++) begin
                if (i < int'(tbl_cnt) && tbl_pwr[i] > best_pwr) begin
                    best_pwr = tbl_pwr[i];
                    best_idx = IW'(i);
                end
            end
            if (&tgt_idx) begin
                sel_ok   = tbl_cnt != '0;
                sel_tune = tbl_tune[best_idx];
                sel_pwr  = tbl_pwr[best_idx];
            end
        end
`endif
    end

    assign retry_ok = retry_cnt < RETRY_LAST;

    always_comb begin
        state_nxt  = state;
        sweep_fail = 1'b0;
        case (state)
            IDLE:   if (i_cmd_val) state_nxt = TRIG;
            TRIG:   if (i_search_trig_rdy) state_nxt = WAIT;
            WAIT: begin
                // A table arriving on the last timeout cycle still counts.
                if (i_search_peaks_val)    state_nxt  = SELECT;
                else if (tmo_cnt == TMO_LAST) sweep_fail = 1'b1;
            end
            SELECT: begin
                if (sel_ok) state_nxt  = LOCK;
                else        sweep_fail = 1'b1;
            end
            LOCK:   if (i_lock_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (sweep_fail) state_nxt = retry_ok ? TRIG : LOCK;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            tgt_idx   <= '0;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            tbl_tune  <= '0;
            tbl_pwr   <= '0;
            tbl_cnt   <= '0;
            lock_tune <= '0;
            lock_pwr  <= '0;
            lock_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_cmd_val) begin
                        tgt_idx   <= i_cmd_target_idx;
                        retry_cnt <= '0;
                    end
                end
                TRIG: if (i_search_trig_rdy) tmo_cnt <= '0;
                WAIT: begin
                    if (i_search_peaks_val) begin
                        tbl_tune <= i_search_ring_tune_peaks;
                        tbl_pwr  <= i_search_pwr_peaks;
                        tbl_cnt  <= i_search_peaks_cnt;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                SELECT: begin
                    if (sel_ok) begin
                        lock_tune <= sel_tune;
                        lock_pwr  <= sel_pwr;
                        lock_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (sweep_fail) begin
                if (retry_ok) begin
                    retry_cnt <= retry_cnt + RW'(1);
                end else begin
                    lock_tune <= '0;
                    lock_pwr  <= '0;
                    lock_err  <= 1'b1;
                end
            end
        end
    end

    assign o_cmd_rdy          = (state == IDLE);
    assign o_search_trig_val  = (state == TRIG);
    assign o_search_peaks_rdy = (state == WAIT);
    assign o_lock_val         = (state == LOCK);
    assign o_lock_ring_tune   = lock_tune;
    assign o_lock_pwr         = lock_pwr;
    assign o_lock_err         = lock_err;
    assign o_mon_retry_cnt    = retry_cnt;

endmodule
